kernel_load: RTL and testbench

KERNEL_LOAD -- requirements
Module: kernel_load

---
 rtl/kernel_load.sv | 113 +++++++++++
 tb/tb_kernel_load.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/kernel_load.sv
// kernel_load: packs streamed kernel beats into memory words and loads them into kernel memory
module kernel_load #(
   parameter int GROUP_NB   = 4,
   parameter int KER_WIDTH  = 16,
   parameter int DEPTH_NB   = 1,
   parameter int MEM_AWIDTH = 8,
   parameter int STR_WIDTH  = 16,
   localparam int W = GROUP_NB * KER_WIDTH * DEPTH_NB
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [MEM_AWIDTH-1:0] cfg_end,
   input  logic                  cfg_set,
   output logic                  cfg_rdy,
   input  logic [STR_WIDTH-1:0]  str_data,
   input  logic                  str_val,
   output logic                  str_rdy,
   output logic [MEM_AWIDTH-1:0] wr_cfg_end,
   output logic                  wr_cfg_set,
   output logic [W-1:0]          wr_data,
   output logic                  wr_data_val,
   input  logic                  wr_data_rdy,
   output logic                  done
);
   localparam int BEATS = W / STR_WIDTH;
   localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
   localparam int CW = MEM_AWIDTH + 1;
   typedef enum logic [1:0] {IDLE, CFG, LOAD, DONE} state_t;
   state_t state_q, state_d;
   logic [MEM_AWIDTH-1:0] end_q, end_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [CW-1:0] packed_q, packed_d, sent_q, sent_d, total;
   logic [W-1:0] pack_q, pack_d, data_q, data_d, merged;
   logic val_q, val_d, beat_acc, word_acc, last_beat;
   assign total = {1'b0, end_q} + CW'(1);
   assign cfg_rdy = state_q == IDLE;
   assign wr_cfg_set = state_q == CFG;
   assign done = state_q == DONE;
   assign wr_cfg_end = end_q;
   assign wr_data = data_q;
   assign wr_data_val = val_q;
   assign str_rdy = (state_q == LOAD) && (packed_q < total) && (!val_q || wr_data_rdy);
   assign beat_acc = str_val && str_rdy;
   assign word_acc = val_q && wr_data_rdy;
   assign last_beat = beat_q == BW'(BEATS - 1);
   // drop the incoming beat into its little-endian slot of the partial word
   always_comb begin
      merged = pack_q;
      for (int k = 0; k < BEATS; k++)
         if (beat_q == BW'(k)) merged[k*STR_WIDTH +: STR_WIDTH] = str_data;
   end
   // next-state, packing and word-handoff logic
   always_comb begin
      state_d = state_q;
      end_d = end_q;
      beat_d = beat_q;
      packed_d = packed_q;
      sent_d = sent_q;
      pack_d = pack_q;
      data_d = data_q;
      val_d = val_q;
      case (state_q)
         IDLE: if (cfg_set) begin
            state_d = CFG;
            end_d = cfg_end;
            beat_d = '0;
            packed_d = '0;
            sent_d = '0;
            pack_d = '0;
         end
         CFG: state_d = LOAD;
         LOAD: begin
            if (word_acc) begin
               val_d = 1'b0;
               sent_d = sent_q + CW'(1);
               if (sent_q + CW'(1) == total) state_d = DONE;
            end
            if (beat_acc) begin
               pack_d = last_beat ? '0 : merged;
               beat_d = last_beat ? '0 : beat_q + 1'b1;
               if (last_beat) begin
                  data_d = merged;
                  val_d = 1'b1;
                  packed_d = packed_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state registers, cleared asynchronously so partial words are discarded
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         end_q <= '0;
         beat_q <= '0;
         packed_q <= '0;
         sent_q <= '0;
         pack_q <= '0;
         data_q <= '0;
         val_q <= 1'b0;
      end else begin
         state_q <= state_d;
         end_q <= end_d;
         beat_q <= beat_d;
         packed_q <= packed_d;
         sent_q <= sent_d;
         pack_q <= pack_d;
         data_q <= data_d;
         val_q <= val_d;
      end
   end
endmodule

// File: tb/tb_kernel_load.sv
// tb_kernel_load: directed and randomized checks of kernel_load against a word-packing model
module tb_kernel_load;
   logic clk = 1'b0, rst, cfg_set, str_val, wr_data_rdy;
   logic [7:0] cfg_end, wr_cfg_end;
   logic [15:0] str_data;
   logic cfg_rdy, str_rdy, wr_cfg_set, wr_data_val, done;
   logic [63:0] wr_data;
   int compared = 0, mismatched = 0;
   int cyc, nb;

   kernel_load dut (
      .clk(clk), .rst(rst), .cfg_end(cfg_end), .cfg_set(cfg_set), .cfg_rdy(cfg_rdy),
      .str_data(str_data), .str_val(str_val), .str_rdy(str_rdy),
      .wr_cfg_end(wr_cfg_end), .wr_cfg_set(wr_cfg_set), .wr_data(wr_data),
      .wr_data_val(wr_data_val), .wr_data_rdy(wr_data_rdy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // word n of a stream whose beat i carries value base+i, beat 0 in the low bits
   function automatic logic [63:0] expw(input int base, input int n);
      logic [63:0] w = '0;
      for (int k = 0; k < 4; k++) w |= 64'(16'(base + 4 * n + k)) << (16 * k);
      return w;
   endfunction

   task automatic run_load(input logic [7:0] e, input int base, input int pv, input int pr,
                           input int pulse_at, output int cycles);
      int nbt = 0, nw = 0, ncfg = 0, ndone = 0, c = 0;
      int total_b = (int'(e) + 1) * 4;
      cfg_set = 1'b1;
      cfg_end = e;
      str_val = 1'b0;
      @(posedge clk); #1;
      cfg_set = 1'b0;
      cfg_end = 8'hA5;
      while (c < 20000) begin
         @(negedge clk);
         if (str_val && str_rdy) nbt++;
         if (wr_data_val && wr_data_rdy) begin
            chk("word", wr_data, expw(base, nw));
            nw++;
         end
         if (wr_cfg_set) ncfg++;
         if (done) ndone++;
         if (ndone > 0 && !done) break;
         @(posedge clk); #1;
         str_val = $urandom_range(99) < pv;
         str_data = 16'(base + nbt);
         wr_data_rdy = $urandom_range(99) < pr;
         cfg_set = c == pulse_at;
         cfg_end = (c == pulse_at) ? 8'd7 : 8'hA5;
         c++;
      end
      cycles = c;
      chk("beats_accepted", 64'(nbt), 64'(total_b));
      chk("words_sent", 64'(nw), 64'(int'(e) + 1));
      chk("cfg_pulses", 64'(ncfg), 64'd1);
      chk("done_pulses", 64'(ndone), 64'd1);
      chk("cfg_end_held", 64'(wr_cfg_end), 64'(e));
      chk("idle_cfg_rdy", 64'(cfg_rdy), 64'd1);
      chk("idle_str_rdy", 64'(str_rdy), 64'd0);
      str_val = 1'b0;
      cfg_set = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b0;
      cfg_set = 1'b0;
      cfg_end = '0;
      str_val = 1'b0;
      str_data = '0;
      wr_data_rdy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
      chk("rst_str_rdy", 64'(str_rdy), 64'd0);
      chk("rst_wr_data_val", 64'(wr_data_val), 64'd0);
      chk("rst_wr_data", wr_data, 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      run_load(8'd1, 1, 100, 100, -1, cyc);
      chk("no_bubble_cycles", 64'(cyc), 64'd11);
      chk("last_word_held", wr_data, 64'h0008000700060005);

      cfg_set = 1'b1;
      cfg_end = 8'd0;
      wr_data_rdy = 1'b0;
      @(posedge clk); #1;
      cfg_set = 1'b0;
      @(negedge clk);
      chk("t2_cfg_set", 64'(wr_cfg_set), 64'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         str_val = 1'b1;
         str_data = 16'(16'h21 + i);
         @(negedge clk);
         chk("t2_str_rdy", 64'(str_rdy), 64'd1);
      end
      @(posedge clk); #1;
      str_data = 16'hBEEF;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_hold_val", 64'(wr_data_val), 64'd1);
         chk("t2_hold_data", wr_data, expw(16'h21, 0));
         chk("t2_stall_str_rdy", 64'(str_rdy), 64'd0);
         @(posedge clk); #1;
      end
      wr_data_rdy = 1'b1;
      @(negedge clk);
      chk("t2_final_str_rdy", 64'(str_rdy), 64'd0);
      @(posedge clk); #1;
      wr_data_rdy = 1'b0;
      str_val = 1'b0;
      @(negedge clk);
      chk("t2_done", 64'(done), 64'd1);
      chk("t2_val_clear", 64'(wr_data_val), 64'd0);
      @(negedge clk);
      chk("t2_done_one_cycle", 64'(done), 64'd0);
      chk("t2_cfg_rdy", 64'(cfg_rdy), 64'd1);
      @(posedge clk); #1;

      run_load(8'd255, 0, 70, 60, -1, cyc);
      run_load(8'd3, 16'h100, 100, 100, 3, cyc);

      cfg_set = 1'b1;
      cfg_end = 8'd3;
      wr_data_rdy = 1'b1;
      @(posedge clk); #1;
      cfg_set = 1'b0;
      nb = 0;
      for (int i = 0; i < 50 && nb < 6; i++) begin
         str_val = 1'b1;
         str_data = 16'(16'h40 + nb);
         @(negedge clk);
         if (str_val && str_rdy) nb++;
         @(posedge clk); #1;
      end
      chk("t5_beats_before_reset", 64'(nb), 64'd6);
      rst = 1'b0;
      #1;
      chk("t5_cfg_rdy", 64'(cfg_rdy), 64'd1);
      chk("t5_str_rdy", 64'(str_rdy), 64'd0);
      chk("t5_wr_cfg_set", 64'(wr_cfg_set), 64'd0);
      chk("t5_wr_cfg_end", 64'(wr_cfg_end), 64'd0);
      chk("t5_wr_data", wr_data, 64'd0);
      chk("t5_wr_data_val", 64'(wr_data_val), 64'd0);
      chk("t5_done", 64'(done), 64'd0);
      str_val = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      run_load(8'd0, 9, 100, 100, -1, cyc);
      chk("t5_word_after_reset", wr_data, 64'h000C000B000A0009);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
